// File: rtl/mod5_seq_checker.sv
// mod5_seq_checker: monitors a mod-MOD counter, tracks its 0..MOD-1 sequence,
// counts wraps and latches the first illegal value or sequence break.
//
// Ports:
//   clk, rst (async, active-low), en, clr_err, cnt_in[3:0]
//   locked, err, err_code[1:0], bad_val[3:0], wrap_pulse, wrap_count[WRAP_W-1:0]
module mod5_seq_checker #(
  parameter int MOD    = 5,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr_err,
  input  logic [3:0]        cnt_in,
  output logic              locked,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [3:0]        bad_val,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count
);

  localparam logic [1:0] SYNC  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] ERROR = 2'd2;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_ILL  = 2'b01;
  localparam logic [1:0] CODE_SEQ  = 2'b10;

  localparam logic [3:0] MOD_V = 4'(MOD);
  localparam logic [3:0] LAST  = 4'(MOD - 1);

  logic [1:0] state;
  logic [3:0] expected;
  logic       illegal;

  assign illegal = (cnt_in >= MOD_V);
  assign locked  = (state == TRACK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SYNC;
      expected   <= '0;
      err        <= 1'b0;
      err_code   <= CODE_NONE;
      bad_val    <= '0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
    end else if (clr_err) begin
      state      <= SYNC;
      expected   <= '0;
      err        <= 1'b0;
      err_code   <= CODE_NONE;
      bad_val    <= '0;
      wrap_pulse <= 1'b0;
    end else if (!en) begin
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      unique case (state)
        SYNC: begin
          if (illegal) begin
            state    <= ERROR;
            err      <= 1'b1;
            err_code <= CODE_ILL;
            bad_val  <= cnt_in;
          end else if (cnt_in == 4'd0) begin
            // First zero seen only establishes lock; it is not a wrap.
            state    <= TRACK;
            expected <= 4'd1;
          end
        end
        TRACK: begin
          if (illegal) begin
            state    <= ERROR;
            err      <= 1'b1;
            err_code <= CODE_ILL;
            bad_val  <= cnt_in;
          end else if (cnt_in != expected) begin
            state    <= ERROR;
            err      <= 1'b1;
            err_code <= CODE_SEQ;
            bad_val  <= cnt_in;
          end else begin
            expected <= (expected == LAST) ? 4'd0 : expected + 4'd1;
            if (cnt_in == 4'd0) begin
              wrap_pulse <= 1'b1;
              wrap_count <= wrap_count + 1'b1;
            end
          end
        end
        ERROR: begin
          // First error wins; only clr_err leaves this state.
        end
        default: begin
          state <= SYNC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod5_seq_checker.sv
// tb_mod5_seq_checker: directed-vector bench for mod5_seq_checker.
// Runs a WRAP_W=8 and a WRAP_W=2 instance on shared stimulus.
module tb_mod5_seq_checker;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr_err;
  logic [3:0] cnt_in;

  logic       locked, err, wrap_pulse;
  logic [1:0] err_code;
  logic [3:0] bad_val;
  logic [7:0] wrap_count;

  logic       locked2, err2, wrap_pulse2;
  logic [1:0] err_code2;
  logic [3:0] bad_val2;
  logic [1:0] wrap_count2;

  int n_vec;
  int n_bad;

  mod5_seq_checker #(.MOD(5), .WRAP_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr_err    (clr_err),
    .cnt_in     (cnt_in),
    .locked     (locked),
    .err        (err),
    .err_code   (err_code),
    .bad_val    (bad_val),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count)
  );

  mod5_seq_checker #(.MOD(5), .WRAP_W(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr_err    (clr_err),
    .cnt_in     (cnt_in),
    .locked     (locked2),
    .err        (err2),
    .err_code   (err_code2),
    .bad_val    (bad_val2),
    .wrap_pulse (wrap_pulse2),
    .wrap_count (wrap_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] v,
                      input logic e,
                      input logic c);
    @(negedge clk);
    cnt_in  = v;
    en      = e;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_err(input string tag,
                         input logic e,
                         input logic [1:0] code,
                         input logic [3:0] bv,
                         input logic lk);
    chk({tag, ".err"}, 32'(err), 32'(e));
    chk({tag, ".code"}, 32'(err_code), 32'(code));
    chk({tag, ".bad"}, 32'(bad_val), 32'(bv));
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
  endtask

  logic [3:0] seq2 [9];
  logic       lk2  [9];
  logic       wp2  [9];
  logic [3:0] cyc  [5];

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    en      = 1'b1;
    clr_err = 1'b0;
    cnt_in  = 4'd3;
    rst     = 1'b1;

    // T1: async reset with cnt_in=3
    #2;
    rst = 1'b0;
    #1;
    chk_err("t1_rst", 1'b0, 2'b00, 4'd0, 1'b0);
    chk("t1_rst.wp", 32'(wrap_pulse), 32'd0);
    chk("t1_rst.wc", 32'(wrap_count), 32'd0);
    chk("t1_rst.wc2", 32'(wrap_count2), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t1_hold.locked", 32'(locked), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(4'd3, 1'b1, 1'b0);
    chk_err("t1_sync", 1'b0, 2'b00, 4'd0, 1'b0);

    // T2: lock then one full wrap
    seq2 = '{4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    lk2  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    wp2  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      step(seq2[i], 1'b1, 1'b0);
      chk($sformatf("t2_lk%0d", i), 32'(locked), 32'(lk2[i]));
      chk($sformatf("t2_wp%0d", i), 32'(wrap_pulse), 32'(wp2[i]));
    end
    chk("t2_wc", 32'(wrap_count), 32'd1);
    chk("t2_err", 32'(err), 32'd0);

    // T3: skip 1->3 breaks the sequence
    step(4'd1, 1'b1, 1'b0);
    chk_err("t3_ok", 1'b0, 2'b00, 4'd0, 1'b1);
    step(4'd3, 1'b1, 1'b0);
    chk_err("t3_brk", 1'b1, 2'b10, 4'd3, 1'b0);
    step(4'd4, 1'b1, 1'b0);
    step(4'd9, 1'b1, 1'b0);
    step(4'd0, 1'b1, 1'b0);
    chk_err("t3_hold", 1'b1, 2'b10, 4'd3, 1'b0);
    chk("t3_wp", 32'(wrap_pulse), 32'd0);
    step(4'd0, 1'b0, 1'b1);
    chk_err("t3_clr", 1'b0, 2'b00, 4'd0, 1'b0);
    chk("t3_wc", 32'(wrap_count), 32'd1);

    // T4: illegal value while tracking (01 beats 10)
    step(4'd0, 1'b1, 1'b0);
    chk("t4_lock", 32'(locked), 32'd1);
    step(4'd7, 1'b1, 1'b0);
    chk_err("t4_ill", 1'b1, 2'b01, 4'd7, 1'b0);
    step(4'd2, 1'b1, 1'b1);
    chk_err("t4_clr", 1'b0, 2'b00, 4'd0, 1'b0);
    chk("t4_wc", 32'(wrap_count), 32'd1);
    step(4'd0, 1'b1, 1'b0);
    chk("t4_relock", 32'(locked), 32'd1);

    // T6: clr_err beats a bad sample in TRACK
    step(4'd9, 1'b1, 1'b1);
    chk_err("t6_prio", 1'b0, 2'b00, 4'd0, 1'b0);

    // Illegal value seen while still in SYNC
    step(4'd12, 1'b1, 1'b0);
    chk_err("sync_ill", 1'b1, 2'b01, 4'd12, 1'b0);
    step(4'd0, 1'b1, 1'b1);
    chk_err("sync_clr", 1'b0, 2'b00, 4'd0, 1'b0);

    // T5: stalls between samples, WRAP_W=2 rollover
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_rst.wc", 32'(wrap_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(4'd0, 1'b1, 1'b0);
    chk("t5_lock", 32'(locked2), 32'd1);
    cyc = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    for (int k = 1; k <= 4; k++) begin
      for (int j = 0; j < 5; j++) begin
        step(4'd7, 1'b0, 1'b0);
        if (j == 0) begin
          chk($sformatf("t5_stall_wp%0d", k), 32'(wrap_pulse2), 32'd0);
          chk($sformatf("t5_stall_lk%0d", k), 32'(locked2), 32'd1);
        end
        step(cyc[j], 1'b1, 1'b0);
        if (j == 4) begin
          chk($sformatf("t5_wp%0d", k), 32'(wrap_pulse2), 32'd1);
          chk($sformatf("t5_wc2_%0d", k), 32'(wrap_count2), 32'(k % 4));
          chk($sformatf("t5_wc8_%0d", k), 32'(wrap_count), 32'(k));
        end else begin
          chk($sformatf("t5_nowp%0d_%0d", k, j), 32'(wrap_pulse2), 32'd0);
        end
      end
    end
    chk("t5_err", 32'(err2), 32'd0);
    chk("t5_code", 32'(err_code2), 32'd0);
    step(4'd7, 1'b0, 1'b0);
    chk("t5_end_wp", 32'(wrap_pulse2), 32'd0);
    chk("t5_end_wc2", 32'(wrap_count2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
